// File: rtl/fp32_sq_if.sv
// fp32_sq_if: operand/result handshake bundle for fp32_square_seq.
interface fp32_sq_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;
  logic        busy;
  modport master (output in_valid, a, out_ready, input in_ready, out_valid, y, busy);
  modport slave  (input in_valid, a, out_ready, output in_ready, out_valid, y, busy);
endinterface

// File: rtl/fp32_square_seq.sv
// fp32_square_seq: sequential fp32 squarer (shift-add mantissa product, RNE).
// Define FP32_SQ_SUBNORMAL_EN for gradual underflow; otherwise tiny results flush to zero.
module fp32_square_seq (
  input logic       clk,
  input logic       rst_n,
  fp32_sq_if.slave  bus
);
  localparam logic [1:0] IDLE = 2'd0, MUL = 2'd1, NORM = 2'd2, DONE = 2'd3;
  logic [1:0]         state_q, state_d;
  logic [23:0]        mant_q, mant_d;
  logic [7:0]         e_q, e_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [47:0]        acc_q, acc_d;
  logic [31:0]        y_q, y_d;
  logic [7:0]         a_exp;
  logic [22:0]        a_frac;
  logic               hi, guard, sticky, rnd;
  logic [23:0]        sig;
  logic [24:0]        sum;
  logic [22:0]        frac;
  logic signed [9:0]  exp_s, exp_r;
  logic [31:0]        uf_y, norm_y;
  assign a_exp  = bus.a[30:23];
  assign a_frac = bus.a[22:0];
  always_comb begin
    hi     = acc_q[47];
    sig    = hi ? acc_q[47:24] : acc_q[46:23];
    guard  = hi ? acc_q[23] : acc_q[22];
    sticky = hi ? |acc_q[22:0] : |acc_q[21:0];
    rnd    = guard & (sticky | sig[0]);
    sum    = {1'b0, sig} + {24'd0, rnd};
    frac   = sum[24] ? sum[23:1] : sum[22:0];
    exp_s  = $signed({1'b0, e_q, 1'b0}) - 10'sd127 + $signed({9'd0, hi});
    exp_r  = exp_s + $signed({9'd0, sum[24]});
    norm_y = (exp_s <= 10'sd0) ? uf_y :
             (exp_r >= 10'sd255) ? 32'h7F80_0000 : {1'b0, exp_r[7:0], frac};
  end
`ifdef FP32_SQ_SUBNORMAL_EN
  logic [9:0]  sh_full;
  logic [4:0]  sh;
  logic [25:0] v, vs;
  logic        lost, s_rnd;
  logic [23:0] s_sum;
  // Shifts past 26 only leave sticky, so clamp there; a carry into bit 23 lands on the min normal.
  always_comb begin
    sh_full = 10'd1 - exp_s;
    sh      = (sh_full > 10'd26) ? 5'd26 : sh_full[4:0];
    v       = {sig, guard, 1'b0};
    vs      = v >> sh;
    lost    = (|(v & ~(26'h3FF_FFFF << sh))) | sticky | vs[0];
    s_rnd   = vs[1] & (lost | vs[2]);
    s_sum   = vs[25:2] + {23'd0, s_rnd};
    uf_y    = {8'd0, s_sum};
  end
`else
  assign uf_y = 32'd0;
`endif
  always_comb begin
    state_d = state_q;
    mant_d  = mant_q;
    e_d     = e_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    y_d     = y_q;
    case (state_q)
      IDLE: if (bus.in_valid) begin
        mant_d = {|a_exp, a_frac};
        e_d    = (a_exp == 8'd0) ? 8'd1 : a_exp;
        cnt_d  = 5'd0;
        acc_d  = 48'd0;
        if (a_exp == 8'hFF) begin
          y_d     = (a_frac != 23'd0) ? 32'h7FC0_0000 : 32'h7F80_0000;
          state_d = DONE;
        end else if (a_exp == 8'd0 && a_frac == 23'd0) begin
          y_d     = 32'd0;
          state_d = DONE;
        end else state_d = MUL;
      end
      MUL: begin
        acc_d   = acc_q + (mant_q[cnt_q] ? ({24'd0, mant_q} << cnt_q) : 48'd0);
        cnt_d   = cnt_q + 5'd1;
        state_d = (cnt_q == 5'd23) ? NORM : MUL;
      end
      NORM: begin
        y_d     = norm_y;
        state_d = DONE;
      end
      default: state_d = bus.out_ready ? IDLE : DONE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      mant_q  <= 24'd0;
      e_q     <= 8'd0;
      cnt_q   <= 5'd0;
      acc_q   <= 48'd0;
      y_q     <= 32'd0;
    end else begin
      state_q <= state_d;
      mant_q  <= mant_d;
      e_q     <= e_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      y_q     <= y_d;
    end
  assign bus.in_ready  = state_q == IDLE;
  assign bus.busy      = state_q != IDLE;
  assign bus.out_valid = state_q == DONE;
  assign bus.y         = y_q;
endmodule

// File: doc/fp32_square_seq.md
# fp32_square_seq

Sequential IEEE754 single-precision squaring unit (y = a*a), the inverse operation to the combinational fp32 square-root block. It is used to check sqrt results by squaring them and to generate sqrt stimulus. It accepts one operand through a valid/ready handshake, builds the 24x24 mantissa product with one shift-add step per cycle, rounds to nearest-even, and holds the result until the consumer accepts it. It is area-lean: one adder, no multiplier array.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand present on a
- in_ready  out  1  unit idle; high only in IDLE
- a  in  32  IEEE754 operand, sampled on the accept edge (in_valid && in_ready)
- out_valid  out  1  result valid on y
- out_ready  in  1  consumer accepts y
- y  out  32  IEEE754 result, registered
- busy  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, MUL, NORM, DONE.
- IDLE: on accept, latch the operand and classify it.
  - NaN input: next state DONE, y=0x7FC00000.
  - ±Inf input: next state DONE, y=0x7F800000.
  - ±0 input: next state DONE, y=0x00000000.
  - Otherwise: next state MUL, count=0, product accumulator=0.
- Operand mapping:
  - exp==0 gives mant={0,frac} and e=1.
  - Otherwise mant={1,frac} and e=exp.
  - The sign is discarded; the result sign is always 0.
- MUL: one multiplier bit per cycle, LSB first. If mant[count] is set, add mant<<count into the 48-bit accumulator. After count==23 the state moves to NORM.
- NORM (one cycle):
  - Biased exponent E = 2e − 127 + p[47], computed in 10-bit signed arithmetic.
  - Significand = p[47:24] if p[47] is set, otherwise p[46:23].
  - Guard bit and sticky bit are taken from the remaining low bits.
  - Round to nearest-even. A mantissa carry-out increments E.
  - E ≥ 255: y=0x7F800000.
  - E ≤ 0: underflow path, see Configuration.
  - Otherwise y={0,E[7:0],sig[22:0]}.
  - Next state DONE.
- DONE: out_valid=1 and y is held stable. On out_valid && out_ready the state returns to IDLE.
- No overlap: a new operand cannot be accepted in the cycle the result is taken. in_ready rises the cycle after.

## Timing
- Reset values: in_ready=1, out_valid=0, y=0x00000000, busy=0. The state is IDLE.
- Asserting rst_n low mid-operation aborts the operation immediately. The partial product is discarded and no result is issued.
- Latency is counted from the accept edge to out_valid high:
  - Special inputs: 1 cycle.
  - Normal and subnormal inputs: 26 cycles (24 MUL cycles, 1 NORM cycle, 1 to register DONE).
- Throughput, with out_ready held high:
  - Normal and subnormal inputs: one result per 28 cycles.
  - Special inputs: one result per 3 cycles.
- out_valid stays high until it is consumed, with no timeout. y changes only on the NORM edge or the special-classification edge.
- in_valid is ignored while busy. The upstream block must hold a until accepted.

## Configuration
- FP32_SQ_SUBNORMAL_EN defined, when E ≤ 0:
  - Right-shift the unrounded 24-bit significand by (1−E), folding shifted-out bits into sticky.
  - Shifts ≥ 25 leave only sticky.
  - Apply RNE. y={0,8'h00,sig[22:0]}.
  - If rounding carries into bit 23, y=0x00800000.
- FP32_SQ_SUBNORMAL_EN undefined: any E ≤ 0 gives y=0x00000000 (flush to zero).
- Subnormal inputs produce 0x00000000 in both modes, since the true result is below 2^-252.

## Test plan
- a=0x40400000 (3.0), out_ready=1 → out_valid 26 cycles after accept, y=0x41100000. Then a=0xC0000000 (−2.0) → y=0x40800000.
- Special inputs, each with y after 1 cycle:
  - 0x7FC00001 → 0x7FC00000
  - 0xFF800000 → 0x7F800000
  - 0x80000000 → 0x00000000
- Rounding and overflow:
  - a=0x3F800001 → y=0x3F800002 (RNE drops the 2^-46 term).
  - a=0x5F800000 (2^64) → y=0x7F800000.
- a=0x1F800000 (2^-64):
  - With FP32_SQ_SUBNORMAL_EN → y=0x00200000.
  - Without it → y=0x00000000.
  - a=0x00000001 → y=0x00000000 in both builds.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → y stable, in_ready=0, busy=1, and a new in_valid is ignored. Then pulse out_ready → in_ready=1 the next cycle.
- Assert rst_n=0 at MUL cycle 10 → all outputs return to reset values at once. The next operand 0x40400000 returns 0x41100000 with full 26-cycle latency.
